sc_stream_decoder: RTL

- Stochastic-to-binary converter; the back end of the SC datapath.
- Consumes the serial stochastic bit produced by a generated SC circuit and counts ones over a fixed window of N = 2**WIN_LOG2 accepted beats.
- Presents the count as a binary result with a done pulse.
- Mirror of the LFSR+comparator stochastic number generator that drives the circuit inputs.

---
 rtl/sc_pkg.sv | 27 ++
 rtl/sc_window_counter.sv | 52 +++++
 rtl/sc_stream_decoder.sv | 112 +++++++++++
 3 files changed

// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing (SC) datapath.
// Holds the decoder state encoding, the result-width rule and the bipolar
// conversion used by the decoder (and by future bipolar SNG blocks).
package sc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sc_state_e;

  // Result width: one bit for the count N itself plus one sign bit.
  function automatic int sc_res_w(input int win_log2);
    return win_log2 + 2;
  endfunction

  // Bipolar SC encoding: value = 2*ones - N, two's complement.
  // Callers truncate to their own result width.
  function automatic logic signed [31:0] sc_bipolar(input logic [31:0] ones,
                                                    input int unsigned win_log2);
    logic signed [31:0] two_x;
    logic signed [31:0] n_val;
    two_x = $signed(ones << 1);
    n_val = $signed(32'd1 << win_log2);
    return two_x - n_val;
  endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Window counters for the SC stream decoder: accepted-beat count and
// ones count, with synchronous clear/enable and a terminal-count flag
// that marks the beat completing the window.
module sc_window_counter #(
  parameter int WIN_LOG2 = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              bit_i,
  output logic [WIN_LOG2:0] beat_cnt_o,
  output logic [WIN_LOG2:0] ones_o,
  output logic              tc_o
);

  localparam int N = 1 << WIN_LOG2;
  localparam logic [WIN_LOG2:0] LAST_BEAT = (WIN_LOG2 + 1)'(N - 1);

  logic [WIN_LOG2:0] beat_cnt_q, beat_cnt_d;
  logic [WIN_LOG2:0] ones_q, ones_d;

  // Next-state: clear wins over enable; an accepted beat bumps both counters.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    ones_d     = ones_q;
    if (clr_i) begin
      beat_cnt_d = '0;
      ones_d     = '0;
    end else if (en_i) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
      ones_d     = ones_q + {{WIN_LOG2{1'b0}}, bit_i};
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      ones_q     <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      ones_q     <= ones_d;
    end
  end

  // Terminal count: the beat being accepted now is beat N.
  assign tc_o       = en_i && !clr_i && (beat_cnt_q == LAST_BEAT);
  assign beat_cnt_o = beat_cnt_q;
  assign ones_o     = ones_q;

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary converter: counts ones over a window of
// N = 2**WIN_LOG2 accepted beats and presents the count with a done pulse.
// Optional build macro SC_DEC_BIPOLAR_EN: result is 2*ones - N (signed)
// instead of the unsigned ones count. Control behaviour is identical.
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int WIN_LOG2 = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  output logic                          busy,
  output logic                          done,
  output logic [sc_res_w(WIN_LOG2)-1:0] result,
  output logic [WIN_LOG2:0]             beat_cnt
);

  localparam int RES_W = sc_res_w(WIN_LOG2);

  sc_state_e          state_q;
  logic               busy_q;
  logic               done_q;
  logic [RES_W-1:0]   result_q, result_d;

  logic               cnt_clr;
  logic               cnt_en;
  logic               cnt_tc;
  logic [WIN_LOG2:0]  ones;
  logic [WIN_LOG2:0]  final_ones;

  // Counter control: clear on window start or abort; count valid beats in RUN.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (state_q == IDLE) begin
      cnt_clr = start;
    end else begin
      cnt_clr = abort;
      cnt_en  = bit_valid && !abort;
    end
  end

  sc_window_counter #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_win_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .bit_i      (bit_in),
    .beat_cnt_o (beat_cnt),
    .ones_o     (ones),
    .tc_o       (cnt_tc)
  );

  // Final count includes the beat being accepted on the completing edge.
  assign final_ones = ones + {{WIN_LOG2{1'b0}}, bit_in};

  // Result conversion: unipolar zero-extend or bipolar 2*ones - N.
  always_comb begin
    result_d = '0;
`ifdef SC_DEC_BIPOLAR_EN
    result_d = RES_W'(sc_bipolar(32'(final_ones), WIN_LOG2));
`else
    result_d = RES_W'(final_ones);
`endif
  end

  // Control FSM with registered busy/done/result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_tc) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= result_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
